// File: rtl/conv_layer_mem.sv
// conv_layer_mem: five-bank feature-map store for a CONV layer with a
// request/run/done sequencer toward the CONV engine. Memory accesses are
// honoured in every sequencer state; the sequencer only drives ready/done.
module conv_layer_mem #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic              busy,
    input  logic [2:0]        csel,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    output logic [4:0]        bank_full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [12:0] CNT_MAX = 13'd8191;

    // Bank depth by select code; zero marks an invalid select.
    function automatic logic [12:0] f_depth(input logic [2:0] sel);
        case (sel)
            3'd1, 3'd2: f_depth = 13'd4096;
            3'd3, 3'd4: f_depth = 13'd1024;
            3'd5:       f_depth = 13'd2048;
            default:    f_depth = 13'd0;
        endcase
    endfunction

    logic [DATA_W-1:0] r_mem0 [0:4095];
    logic [DATA_W-1:0] r_mem1 [0:4095];
    logic [DATA_W-1:0] r_mem2 [0:1023];
    logic [DATA_W-1:0] r_mem3 [0:1023];
    logic [DATA_W-1:0] r_mem4 [0:2047];

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [12:0]       r_cnt [0:4];
    logic [DATA_W-1:0] w_rd_mem;
    logic [12:0]       w_depth;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_enter_req;

    // Both ports share one bank select, so one depth serves both checks.
    assign w_depth     = f_depth(csel);
    assign w_wr_ok     = (w_depth != 13'd0) && (13'(caddr_wr) < w_depth);
    assign w_rd_ok     = (w_depth != 13'd0) && (13'(caddr_rd) < w_depth);
    assign w_enter_req = (r_state != REQ) && (w_next == REQ);

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Sequencer next-state; start is ignored while in REQ or RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = REQ;
            REQ:     if (busy)  w_next = RUN;
            RUN:     if (!busy) w_next = DONE;
            DONE:    if (start) w_next = REQ;
            default: w_next = IDLE;
        endcase
    end

    // ready/done registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_next == REQ);
            r_done  <= (w_next == DONE);
        end
    end

    // Memory write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (cwr && w_wr_ok) begin
            case (csel)
                3'd1:    r_mem0[caddr_wr[11:0]] <= cdata_wr;
                3'd2:    r_mem1[caddr_wr[11:0]] <= cdata_wr;
                3'd3:    r_mem2[caddr_wr[9:0]]  <= cdata_wr;
                3'd4:    r_mem3[caddr_wr[9:0]]  <= cdata_wr;
                3'd5:    r_mem4[caddr_wr[10:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

    // Array read mux for the selected bank.
    always_comb begin
        w_rd_mem = '0;
        case (csel)
            3'd1:    w_rd_mem = r_mem0[caddr_rd[11:0]];
            3'd2:    w_rd_mem = r_mem1[caddr_rd[11:0]];
            3'd3:    w_rd_mem = r_mem2[caddr_rd[9:0]];
            3'd4:    w_rd_mem = r_mem3[caddr_rd[9:0]];
            3'd5:    w_rd_mem = r_mem4[caddr_rd[10:0]];
            default: w_rd_mem = '0;
        endcase
    end

    // Registered read data: write-first bypass on address match, zero on invalid access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (crd) begin
            if (!w_rd_ok)                              r_rdata <= '0;
            else if (cwr && w_wr_ok && caddr_wr == caddr_rd) r_rdata <= cdata_wr;
            else                                       r_rdata <= w_rd_mem;
        end
    end

    // Sticky error; cleared on entry to REQ, which takes priority over a new error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                       r_err <= 1'b0;
        else if (w_enter_req)                             r_err <= 1'b0;
        else if ((cwr && !w_wr_ok) || (crd && !w_rd_ok))  r_err <= 1'b1;
    end

    // Per-bank saturating write counters, cleared on entry to REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
        end else if (w_enter_req) begin
            for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 5; k++)
                if (cwr && w_wr_ok && csel == 3'(k + 1) && r_cnt[k] != CNT_MAX)
                    r_cnt[k] <= r_cnt[k] + 13'd1;
        end
    end

    // A bank is full once its count reaches its depth.
    always_comb begin
        bank_full = '0;
        for (int k = 0; k < 5; k++)
            bank_full[k] = (r_cnt[k] >= f_depth(3'(k + 1)));
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign err      = r_err;
    assign cdata_rd = r_rdata;

endmodule
